haz_pipe_sched: RTL and testbench

Pipeline stage-control scheduler driven by the hazard-detect flags (data, structural, control, forward-ok, branch-resolved, branch-correct).
- Sequences stall, bubble and flush enables for the PC, IF/ID and ID/EX registers of the 5-stage pipeline.
- Applies fixed hazard priority and bounds every stall with a watchdog.
- Sits between the hazard detector and the pipeline register enables.

---
 rtl/haz_pipe_sched_if.sv | 37 +++
 rtl/haz_pipe_sched.sv | 155 +++++++++++++++
 tb/tb_haz_pipe_sched.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/haz_pipe_sched_if.sv
// Hazard scheduler bundle.
// Carries the detector-side hazard flags into the scheduler, and the stage
// enables, status and counters back out to the pipeline.
//   master : hazard detector / pipeline side (drives the flags, reads the enables)
//   slave  : haz_pipe_sched
interface haz_pipe_sched_if #(
  parameter int unsigned CNT_W = 8
);
  logic             en;
  logic             haz_data;
  logic             fwd_ok;
  logic             haz_str;
  logic             haz_ctrl;
  logic             br_valid;
  logic             br_ok;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             fwd_use;
  logic [2:0]       state;
  logic             timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output en, haz_data, fwd_ok, haz_str, haz_ctrl, br_valid, br_ok,
    input  pc_en, ifid_en, ifid_flush, idex_bubble, fwd_use, state, timeout,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  en, haz_data, fwd_ok, haz_str, haz_ctrl, br_valid, br_ok,
    output pc_en, ifid_en, ifid_flush, idex_bubble, fwd_use, state, timeout,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/haz_pipe_sched.sv
// Pipeline stage-control scheduler.
// Turns hazard-detect flags into stall / bubble / flush enables for the PC,
// IF/ID and ID/EX registers. The priority order is fixed, and a watchdog
// bounds the time spent in any stall state.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   bus        haz_pipe_sched_if.slave: en, hazard flags in; stage enables,
//              fwd_use, state, sticky timeout and perf counters out
// Optional build macro HAZ_PERF_CNT_EN: builds the stall/flush counters.
// When it is undefined, both counter ports are tied to 0.
module haz_pipe_sched #(
  parameter int unsigned FLUSH_CYC = 2,
  parameter int unsigned STR_MIN   = 1,
  parameter int unsigned MAX_STALL = 15,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  haz_pipe_sched_if.slave  bus
);
  localparam logic [2:0] S_RUN    = 3'd0;
  localparam logic [2:0] S_DSTALL = 3'd1;
  localparam logic [2:0] S_SSTALL = 3'd2;
  localparam logic [2:0] S_BWAIT  = 3'd3;
  localparam logic [2:0] S_FLUSH  = 3'd4;

  localparam int unsigned     DW_W    = 8;
  localparam logic [DW_W-1:0] DW_MAX  = {DW_W{1'b1}};
  localparam logic [DW_W-1:0] WD_LIM  = DW_W'(MAX_STALL - 1);
  localparam logic [DW_W-1:0] FL_LIM  = DW_W'(FLUSH_CYC - 1);
  localparam logic [DW_W-1:0] STR_LIM = DW_W'(STR_MIN);

  logic [2:0]      state_q, state_d;
  logic [DW_W-1:0] dwell_q, dwell_d;
  logic            timeout_q, timeout_d;
  logic            fwd_use_q, fwd_use_d;
  logic            mispredict_c;
  logic            stall_st_c;

  assign mispredict_c = bus.haz_ctrl & bus.br_valid & ~bus.br_ok;
  assign stall_st_c   = (state_q == S_DSTALL) | (state_q == S_SSTALL) |
                        (state_q == S_BWAIT);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_RUN;
      dwell_q   <= '0;
      timeout_q <= 1'b0;
      fwd_use_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dwell_q   <= dwell_d;
      timeout_q <= timeout_d;
      fwd_use_q <= fwd_use_d;
    end
  end

  // Next state, dwell, watchdog and forwarding pulse.
  always_comb begin
    state_d   = state_q;
    dwell_d   = dwell_q;
    timeout_d = timeout_q;
    fwd_use_d = 1'b0;
    if (bus.en) begin
      case (state_q)
        S_RUN: begin
          // Any haz_ctrl outranks data and structural hazards.
          if (bus.haz_ctrl) begin
            if (!bus.br_valid)    state_d = S_BWAIT;
            else if (!bus.br_ok)  state_d = S_FLUSH;
          end else if (bus.haz_data && !bus.fwd_ok) begin
            state_d = S_DSTALL;
          end else if (bus.haz_str) begin
            state_d = S_SSTALL;
          end
          fwd_use_d = ~bus.haz_ctrl & bus.haz_data & bus.fwd_ok;
        end
        S_BWAIT: begin
          if (bus.br_valid) state_d = bus.br_ok ? S_RUN : S_FLUSH;
        end
        S_DSTALL: begin
          if (mispredict_c)                    state_d = S_FLUSH;
          else if (!bus.haz_data || bus.fwd_ok) state_d = S_RUN;
        end
        S_SSTALL: begin
          if (mispredict_c)                              state_d = S_FLUSH;
          else if ((dwell_q >= STR_LIM) && !bus.haz_str) state_d = S_RUN;
        end
        S_FLUSH: begin
          if (dwell_q >= FL_LIM) state_d = S_RUN;
        end
        default: state_d = S_RUN;
      endcase
      // Watchdog overrides every stall exit except a mispredict.
      if (stall_st_c && (dwell_q >= WD_LIM)) begin
        timeout_d = 1'b1;
        state_d   = mispredict_c ? S_FLUSH : S_RUN;
      end
      if (state_d != state_q)    dwell_d = '0;
      else if (dwell_q != DW_MAX) dwell_d = dwell_q + DW_W'(1);
    end
  end

  // Stage-enable decode of the current state.
  always_comb begin
    bus.pc_en       = 1'b0;
    bus.ifid_en     = 1'b0;
    bus.ifid_flush  = 1'b0;
    bus.idex_bubble = 1'b0;
    case (state_q)
      S_RUN: begin
        bus.pc_en   = 1'b1;
        bus.ifid_en = 1'b1;
      end
      S_DSTALL, S_SSTALL: bus.idex_bubble = 1'b1;
      S_FLUSH: begin
        bus.pc_en       = 1'b1;
        bus.ifid_flush  = 1'b1;
        bus.idex_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.state   = state_q;
  assign bus.timeout = timeout_q;
  assign bus.fwd_use = fwd_use_q;

`ifdef HAZ_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Saturating stall-cycle and flush-entry counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (bus.en) begin
      if (stall_st_c && (stall_cnt_q != CNT_MAX))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if ((state_d == S_FLUSH) && (state_q != S_FLUSH) && (flush_cnt_q != CNT_MAX))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`else
  assign bus.stall_cnt = '0;
  assign bus.flush_cnt = '0;
`endif
endmodule

// File: tb/tb_haz_pipe_sched.sv
// Testbench for haz_pipe_sched.
// It applies a table of directed vectors, then resets in the middle of a
// flush, then runs randomized traffic against a behavioural model.
module tb_haz_pipe_sched;
  localparam int unsigned FLUSH_CYC = 2;
  localparam int unsigned STR_MIN   = 1;
  localparam int unsigned MAX_STALL = 15;
  localparam int unsigned CNT_W     = 8;
  localparam int          CMAX      = (1 << CNT_W) - 1;
`ifdef HAZ_PERF_CNT_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  // Input vector bit order: {en, haz_data, fwd_ok, haz_str, haz_ctrl, br_valid, br_ok}.
  localparam logic [6:0] IDLE   = 7'b1000000;
  localparam logic [6:0] BROK   = 7'b1000111;
  localparam logic [6:0] BWIN   = 7'b1000100;
  localparam logic [6:0] MISP   = 7'b1000110;
  localparam logic [6:0] MISPD  = 7'b1100110;
  localparam logic [6:0] FWD    = 7'b1110000;
  localparam logic [6:0] DHAZ   = 7'b1100000;
  localparam logic [6:0] SHAZ   = 7'b1001000;
  localparam logic [6:0] CTDA   = 7'b1100100;
  localparam logic [6:0] ENOFF  = 7'b0000000;
  localparam logic [6:0] ENOFFW = 7'b0110000;

  typedef struct {
    logic [6:0] in;
    logic [2:0] st;
    logic       fw;
    logic       to;
    logic       cc;
    int         es;
    int         ef;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  int m_st, m_dw, m_stall, m_flush;
  bit m_to, m_fw;

  haz_pipe_sched_if #(.CNT_W(CNT_W)) bus ();

  haz_pipe_sched #(
    .FLUSH_CYC(FLUSH_CYC), .STR_MIN(STR_MIN), .MAX_STALL(MAX_STALL), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] decode(input logic [2:0] st);
    case (st)
      3'd0:       decode = 4'b1100;
      3'd1, 3'd2: decode = 4'b0001;
      3'd4:       decode = 4'b1011;
      default:    decode = 4'b0000;
    endcase
  endfunction

  function automatic logic [8:0] act_out();
    act_out = {bus.state, bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_bubble,
               bus.fwd_use, bus.timeout};
  endfunction

  function automatic logic [8:0] exp_out(input logic [2:0] st, input logic fw, input logic to);
    exp_out = {st, decode(st), fw, to};
  endfunction

  function automatic void add(input logic [6:0] in, input logic [2:0] st, input logic fw,
                              input logic to, input logic cc, input int es, input int ef);
    vec_t v;
    v.in = in; v.st = st; v.fw = fw; v.to = to; v.cc = cc; v.es = es * PERF; v.ef = ef * PERF;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] v);
    {bus.en, bus.haz_data, bus.fwd_ok, bus.haz_str, bus.haz_ctrl, bus.br_valid, bus.br_ok} = v;
  endtask

  task automatic model_reset();
    m_st = 0; m_dw = 0; m_stall = 0; m_flush = 0; m_to = 0; m_fw = 0;
  endtask

  // Applies the scheduling rules for one rising edge. m_dw holds the number of
  // cycles already completed in the current state.
  task automatic model_edge(input logic [6:0] v);
    bit en, hd, fo, hs, hc, bv, bo, mis, stalled;
    int nxt;
    {en, hd, fo, hs, hc, bv, bo} = v;
    m_fw = 0;
    if (en) begin
      mis     = hc && bv && !bo;
      stalled = (m_st == 1) || (m_st == 2) || (m_st == 3);
      nxt     = m_st;
      case (m_st)
        0: begin
          if (mis)             nxt = 4;
          else if (hc && bv)   nxt = 0;
          else if (hc)         nxt = 3;
          else if (hd && !fo)  nxt = 1;
          else if (hs)         nxt = 2;
          m_fw = !hc && hd && fo;
        end
        1: if (mis) nxt = 4; else if (!hd || fo) nxt = 0;
        2: if (mis) nxt = 4; else if (m_dw >= STR_MIN && !hs) nxt = 0;
        3: if (bv) nxt = bo ? 0 : 4;
        default: if (m_dw + 1 == FLUSH_CYC) nxt = 0;
      endcase
      if (stalled && (m_dw + 1 == MAX_STALL)) begin
        m_to = 1;
        nxt  = mis ? 4 : 0;
      end
      if (stalled && m_stall < CMAX) m_stall++;
      if (nxt == 4 && m_st != 4 && m_flush < CMAX) m_flush++;
      m_dw = (nxt == m_st) ? m_dw + 1 : 0;
      m_st = nxt;
    end
  endtask

  task automatic rand_phase(input int cycles, input int p_hd, input int p_fo, input int p_hs,
                            input int p_hc, input int p_bv);
    logic [6:0] v;
    for (int i = 0; i < cycles; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        chk("rand_reset", {23'd0, act_out()}, {23'd0, exp_out(3'd0, 1'b0, 1'b0)});
        rst = 1'b0;
      end
      v[6] = ($urandom_range(0, 99) < 90);
      v[5] = ($urandom_range(0, 99) < p_hd);
      v[4] = ($urandom_range(0, 99) < p_fo);
      v[3] = ($urandom_range(0, 99) < p_hs);
      v[2] = ($urandom_range(0, 99) < p_hc);
      v[1] = ($urandom_range(0, 99) < p_bv);
      v[0] = ($urandom_range(0, 99) < 60);
      drive(v);
      @(posedge clk);
      model_edge(v);
      #1;
      chk($sformatf("rand%0d_out", i), {23'd0, act_out()},
          {23'd0, exp_out(3'(m_st), m_fw, m_to)});
      chk($sformatf("rand%0d_cnt", i), {bus.stall_cnt, bus.flush_cnt},
          32'({CNT_W'(m_stall * PERF), CNT_W'(m_flush * PERF)}));
    end
  endtask

  initial begin
    // Directed table: the expected state, fwd_use and timeout are given for
    // the cycle after each vector is sampled.
    add(BROK, 0, 0, 0, 1, 0, 0);
    repeat (3) add(BWIN, 3, 0, 0, 0, 0, 0);
    add(MISP, 4, 0, 0, 0, 0, 0);
    add(IDLE, 4, 0, 0, 0, 0, 0);
    add(IDLE, 0, 0, 0, 1, 3, 1);
    add(FWD,  0, 1, 0, 0, 0, 0);
    add(IDLE, 0, 0, 0, 0, 0, 0);
    repeat (4) add(DHAZ, 1, 0, 0, 0, 0, 0);
    add(IDLE, 0, 0, 0, 1, 7, 1);
    repeat (2) add(SHAZ, 2, 0, 0, 0, 0, 0);
    add(IDLE, 0, 0, 0, 1, 9, 1);
    add(CTDA, 3, 0, 0, 0, 0, 0);
    add(BROK, 0, 0, 0, 1, 10, 1);
    repeat (3) add(DHAZ, 1, 0, 0, 0, 0, 0);
    add(MISPD, 4, 0, 0, 0, 0, 0);
    add(IDLE, 4, 0, 0, 0, 0, 0);
    add(IDLE, 0, 0, 0, 1, 13, 2);
    for (int k = 1; k <= 20; k++)
      add(DHAZ, (k == 16) ? 3'd0 : 3'd1, 0, (k >= 16), 0, 0, 0);
    add(IDLE, 0, 0, 1, 1, 32, 2);
    add(DHAZ, 1, 0, 1, 0, 0, 0);
    add(ENOFF, 1, 0, 1, 0, 0, 0);
    add(ENOFFW, 1, 0, 1, 0, 0, 0);
    add(IDLE, 0, 0, 1, 0, 0, 0);
    add(ENOFFW, 0, 0, 1, 1, 33, 2);
    add(MISP, 4, 0, 1, 1, 33, 3);

    rst = 1'b1;
    drive(IDLE);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", {23'd0, act_out()}, {23'd0, exp_out(3'd0, 1'b0, 1'b0)});
    chk("reset_cnt", {bus.stall_cnt, bus.flush_cnt}, 32'd0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].in);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d", i), {23'd0, act_out()},
          {23'd0, exp_out(tbl[i].st, tbl[i].fw, tbl[i].to)});
      if (tbl[i].cc)
        chk($sformatf("row%0d_cnt", i), {bus.stall_cnt, bus.flush_cnt},
            32'({CNT_W'(tbl[i].es), CNT_W'(tbl[i].ef)}));
    end

    // The DUT is in FLUSH here. An asynchronous reset must abort it without
    // waiting for a clock edge.
    #2 rst = 1'b1;
    #1;
    chk("midflush_rst_out", {23'd0, act_out()}, {23'd0, exp_out(3'd0, 1'b0, 1'b0)});
    chk("midflush_rst_cnt", {bus.stall_cnt, bus.flush_cnt}, 32'd0);
    #2 rst = 1'b0;
    model_reset();

    rand_phase(1500, 30, 50, 20, 20, 40);
    rand_phase(1500, 80, 10, 30, 15, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
